// File: rtl/sdram_cmd_arbiter_if.sv
// sdram_cmd_arbiter_if: sub-controller handshakes plus SDRAM pin bus shared through the command arbiter
// Ports/modports:
//   master - sub-controller side: drives initial_done, *_req, *_done, *_cmd, *_addr, *_ba; sees grants, breaks, sdram_*
//   slave  - arbiter side: the reverse
interface sdram_cmd_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2
);
  logic              initial_done;
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic              aref_req;
  logic              aref_en;
  logic              ref_done;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              wr_req;
  logic              wr_en;
  logic              wr_break;
  logic              wr_done;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [BA_W-1:0]   wr_ba;
  logic              rd_req;
  logic              rd_en;
  logic              rd_break;
  logic              rd_done;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [BA_W-1:0]   rd_ba;
  logic              sdram_cke;
  logic [3:0]        sdram_cmd;
  logic [BA_W-1:0]   sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  modport master (
    output initial_done, init_cmd, init_addr,
    output aref_req, ref_done, aref_cmd, aref_addr,
    output wr_req, wr_done, wr_cmd, wr_addr, wr_ba,
    output rd_req, rd_done, rd_cmd, rd_addr, rd_ba,
    input  aref_en, wr_en, wr_break, rd_en, rd_break,
    input  sdram_cke, sdram_cmd, sdram_ba, sdram_addr
  );
  modport slave (
    input  initial_done, init_cmd, init_addr,
    input  aref_req, ref_done, aref_cmd, aref_addr,
    input  wr_req, wr_done, wr_cmd, wr_addr, wr_ba,
    input  rd_req, rd_done, rd_cmd, rd_addr, rd_ba,
    output aref_en, wr_en, wr_break, rd_en, rd_break,
    output sdram_cke, sdram_cmd, sdram_ba, sdram_addr
  );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter: shares the SDRAM command/address bus between init, refresh, write and read controllers
// Ports: sclk clock; snrst async active-low reset; bus (slave modport) carries requests, grants,
//   breaks, done strobes, per-source command/address and the registered sdram_* pin outputs.
// Option: define SDRAM_ARB_RR_EN for round-robin write/read arbitration (default: write over read).
module sdram_cmd_arbiter #(
  parameter int         ADDR_W  = 13,
  parameter int         BA_W    = 2,
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input logic                sclk,
  input logic                snrst,
  sdram_cmd_arbiter_if.slave bus
);
  typedef enum logic [2:0] {INIT, IDLE, AREF, WRITE, READ} state_t;
  state_t            state, next;
  logic              ref_pend;
  logic              wr_prio;
  logic              pick_wr;
  logic [3:0]        cmd_d;
  logic [ADDR_W-1:0] addr_d;
  logic [BA_W-1:0]   ba_d;
`ifdef SDRAM_ARB_RR_EN
  // 1 = last write/read grant went to the reader
  logic last_grant;
  always_ff @(posedge sclk or negedge snrst)
    if (!snrst) last_grant <= 1'b1;
    else if (state == IDLE && next == WRITE) last_grant <= 1'b0;
    else if (state == IDLE && next == READ) last_grant <= 1'b1;
  assign wr_prio = last_grant;
`else
  assign wr_prio = 1'b1;
`endif
  assign pick_wr = bus.wr_req && (!bus.rd_req || wr_prio);
  always_comb begin
    next = state;
    unique case (state)
      INIT:    next = bus.initial_done ? IDLE : INIT;
      IDLE:    next = ref_pend ? AREF : pick_wr ? WRITE : bus.rd_req ? READ : IDLE;
      AREF:    next = bus.ref_done ? IDLE : AREF;
      WRITE:   next = bus.wr_done ? IDLE : WRITE;
      READ:    next = bus.rd_done ? IDLE : READ;
      default: next = INIT;
    endcase
  end
  always_comb begin
    cmd_d  = state == INIT ? bus.init_cmd : state == AREF ? bus.aref_cmd :
             state == WRITE ? bus.wr_cmd : state == READ ? bus.rd_cmd : CMD_NOP;
    addr_d = state == INIT ? bus.init_addr : state == AREF ? bus.aref_addr :
             state == WRITE ? bus.wr_addr : state == READ ? bus.rd_addr : '0;
    ba_d   = state == WRITE ? bus.wr_ba : state == READ ? bus.rd_ba : '0;
  end
  always_ff @(posedge sclk or negedge snrst)
    if (!snrst) begin
      state          <= INIT;
      ref_pend       <= 1'b0;
      bus.aref_en    <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.rd_en      <= 1'b0;
      bus.sdram_cmd  <= CMD_NOP;
      bus.sdram_addr <= '0;
      bus.sdram_ba   <= '0;
    end else begin
      state          <= next;
      // a new request wins over the clear taken on the IDLE->AREF grant
      ref_pend       <= (bus.aref_req && bus.initial_done) || (ref_pend && !(state == IDLE && next == AREF));
      bus.aref_en    <= state == IDLE && next == AREF;
      bus.wr_en      <= state == IDLE && next == WRITE;
      bus.rd_en      <= state == IDLE && next == READ;
      bus.sdram_cmd  <= cmd_d;
      bus.sdram_addr <= addr_d;
      bus.sdram_ba   <= ba_d;
    end
  assign bus.wr_break  = ref_pend && state == WRITE;
  assign bus.rd_break  = ref_pend && state == READ;
  assign bus.sdram_cke = 1'b1;
endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Owns the single SDRAM command/address bus. Shares it between four sub-controllers: init, auto-refresh, write and read.
- Holds the bus for init until `initial_done`, then grants one of refresh, write or read at a time.
- Refresh has the highest priority. A refresh request that arrives during a write or read burst makes that burst stop at its next burst boundary.
- Sits between the sub-controllers and the SDRAM pin driver. Command outputs are registered.

Parameters:
- ADDR_W, 13, SDRAM address width.
- BA_W, 2, bank address width.
- CMD_NOP, 4'b0111, idle command {cs_n,ras_n,cas_n,we_n}.

Ports:
- sclk  in  1  clock
- snrst  in  1  asynchronous active-low reset
- initial_done  in  1  level; init sequence complete
- init_cmd  in  4  init command
- init_addr  in  ADDR_W  init address
- aref_req  in  1  single-cycle refresh request pulse
- aref_en  out  1  single-cycle grant pulse to refresh controller
- ref_done  in  1  refresh sequence complete (level, held until controller clears)
- aref_cmd  in  4  refresh command
- aref_addr  in  ADDR_W  refresh address
- wr_req  in  1  level; write pending
- wr_en  out  1  single-cycle grant pulse to writer
- wr_break  out  1  level; writer must end at next burst boundary
- wr_done  in  1  single-cycle; writer released the bus
- wr_cmd  in  4  writer command
- wr_addr  in  ADDR_W  writer address
- wr_ba  in  BA_W  writer bank
- rd_req, rd_en, rd_break, rd_done, rd_cmd, rd_addr, rd_ba: read equivalents, same directions, widths and rules
- sdram_cke  out  1  clock enable
- sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n}
- sdram_ba  out  BA_W  bank address
- sdram_addr  out  ADDR_W  address

Behaviour:
- Reset, asynchronous on snrst low:
  - state = INIT.
  - sdram_cmd = CMD_NOP, sdram_addr = 0, sdram_ba = 0, sdram_cke = 1.
  - aref_en, wr_en, rd_en, wr_break, rd_break = 0; ref_pend = 0.
- Reset mid-operation aborts everything and returns to INIT.
- States and transitions:
  - INIT: goes to IDLE when initial_done = 1.
  - IDLE: goes to AREF if ref_pend, else to WRITE if wr_req, else to READ if rd_req, else stays.
  - AREF: goes to IDLE when ref_done = 1.
  - WRITE: goes to IDLE when wr_done = 1.
  - READ: goes to IDLE when rd_done = 1.
- ref_pend:
  - Set by aref_req in any state once initial_done = 1.
  - Cleared on the IDLE→AREF transition.
  - Set has priority over clear when both occur in the same cycle. A second aref_req while ref_pend is set is absorbed, not counted.
  - aref_req during INIT is ignored.
- Grant pulses:
  - aref_en, wr_en and rd_en are registered.
  - Each is high for exactly the one cycle after the matching IDLE→X transition, i.e. in the first cycle in state X.
  - Never more than one grant is high.
- Break signals:
  - wr_break = ref_pend while state = WRITE. rd_break = ref_pend while state = READ.
  - Both are deasserted in every other state.
- Command mux:
  - Selects the source by current state: INIT→init_*, AREF→aref_*, WRITE→wr_*, READ→rd_*, IDLE→NOP with addr 0.
  - The selection is registered onto sdram_* with 1-cycle latency.
  - sdram_ba = 0 in INIT, AREF and IDLE.
- A done pulse arriving in a non-matching state is ignored.
- Minimum spacing: after returning to IDLE, one full IDLE cycle with NOP on the bus before the next grant.
- wr_req and rd_req both high in IDLE with ref_pend = 0: write wins (fixed priority, default build).

Optional Feature:
- Macro: SDRAM_ARB_RR_EN.
- Defined:
  - Round-robin between write and read: a 1-bit last_grant register (reset = read) gives write priority if the last grant was read, and vice versa.
  - Refresh priority is unchanged.
- Undefined: fixed write-over-read priority; no last_grant register.

Test Plan:
- Reset, then initial_done raised at cycle 20 with init_cmd driven → sdram_cmd follows init_cmd one cycle later; after initial_done, IDLE with sdram_cmd = 4'b0111.
- aref_req pulse in IDLE → aref_en high for exactly 1 cycle two cycles later; sdram_cmd shows 0001 then 0010 from aref_cmd; returns to IDLE after ref_done; ref_pend = 0.
- wr_req held, writer returns wr_done after 10 cycles; aref_req pulses at write cycle 3 → wr_break = 1 from the next cycle until wr_done. Then one IDLE cycle, then aref_en pulses before any new write or read.
- wr_req and rd_req both high in IDLE:
  - default build → wr_en first; rd_en after wr_done plus the IDLE cycle.
  - with SDRAM_ARB_RR_EN and both held across 3 grants → sequence is write, read, write.
- aref_req during INIT → no aref_en after initial_done.
- Two aref_req pulses during one read → exactly one refresh.
- snrst low for 2 cycles during WRITE → outputs return to reset values immediately; state = INIT; wr_en is not re-issued until initial_done.
